// File: rtl/iomem_master.sv
// iomem_master: turns single commands into iomem bus transfers.
// One command is accepted in IDLE, driven on the iomem bus in REQ until the
// responder pulses iomem_ready (or the wait timer expires), and then held as a
// response in RESP until the consumer takes it.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   cmd_valid/ready        command handshake; cmd_write, cmd_addr, cmd_wdata, cmd_wstrb
//   rsp_valid/ready        response handshake; rsp_rdata, rsp_err
//   iomem_valid/ready      bus request / responder completion pulse
//   iomem_addr/wdata/wstrb bus address, write data, byte strobes (0000 = read)
//   iomem_rdata            responder read data
//   busy                   high whenever the FSM is not IDLE
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// REQ   | bus transfer in flight, iomem_valid high, wait timer running
// RESP  | response presented, held until rsp_ready
module iomem_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  output logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // The wait timer is a down-counter: loaded with TIMEOUT_CYCLES-1 on accept so
  // that terminal count (zero) is reached in the TIMEOUT_CYCLES-th REQ cycle.
  localparam logic [15:0] WAIT_LOAD =
    (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic        cmd_fire;
  logic        cmd_illegal;
  logic        timeout_hit;

  assign cmd_fire    = cmd_valid && cmd_ready;
  assign cmd_illegal = cmd_write && (cmd_wstrb == 4'b0000);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == 16'd0);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; iomem_ready is checked before the timer so ready wins
  // on the expiry cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          state_nxt = cmd_illegal ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (iomem_ready || timeout_hit) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    cmd_ready   = resetn && (state == S_IDLE);
    iomem_valid = (state == S_REQ);
    rsp_valid   = (state == S_RESP);
    busy        = (state != S_IDLE);
  end

  // Command capture, wait timer and response registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_addr  <= 32'd0;
      iomem_wdata <= 32'd0;
      iomem_wstrb <= 4'b0000;
      rsp_rdata   <= 32'd0;
      rsp_err     <= 1'b0;
      wait_cnt    <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            iomem_addr  <= cmd_addr;
            iomem_wdata <= cmd_write ? cmd_wdata : 32'd0;
            iomem_wstrb <= cmd_write ? cmd_wstrb : 4'b0000;
            wait_cnt    <= WAIT_LOAD;
            rsp_rdata   <= 32'd0;
            rsp_err     <= cmd_illegal;
          end
        end
        S_REQ: begin
          if (iomem_ready) begin
            // Zero-strobe writes never reach REQ, so wstrb==0 here means a read.
            rsp_rdata <= (iomem_wstrb == 4'b0000) ? iomem_rdata : 32'd0;
            rsp_err   <= 1'b0;
          end else if (timeout_hit) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_master.sv
module tb_iomem_master;

  logic        clk;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_rdata;
  logic        busy;

  logic [31:0] gpio_reg;
  int          checks;
  int          failures;
  int          vcount;

  iomem_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_wstrb (iomem_wstrb),
    .iomem_rdata (iomem_rdata),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GPIO responder model: byte-strobed register, read data always visible.
  always @(posedge clk) begin
    if (!resetn) begin
      gpio_reg <= 32'd0;
    end else if (iomem_valid && iomem_ready) begin
      for (int b = 0; b < 4; b++) begin
        if (iomem_wstrb[b]) gpio_reg[8*b +: 8] <= iomem_wdata[8*b +: 8];
      end
    end
  end
  assign iomem_rdata = gpio_reg;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = wstrb;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    resetn      = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = 32'd0;
    cmd_wdata   = 32'd0;
    cmd_wstrb   = 4'b0000;
    rsp_ready   = 1'b0;
    iomem_ready = 1'b0;

    // Reset state
    tick(2);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_iomem_valid", {31'd0, iomem_valid}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_iomem_addr", iomem_addr, 32'd0);
    chk("rst_iomem_wstrb", {28'd0, iomem_wstrb}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    resetn = 1'b1;
    tick();
    chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Write 0xA5 to GPIO byte 0, responder ready after 1 cycle
    set_cmd(1'b1, 32'h0300_0000, 32'h0000_00A5, 4'b0001);
    tick();
    cmd_valid = 1'b0;
    chk("wr_iomem_valid", {31'd0, iomem_valid}, 32'd1);
    chk("wr_iomem_addr", iomem_addr, 32'h0300_0000);
    chk("wr_iomem_wdata", iomem_wdata, 32'h0000_00A5);
    chk("wr_iomem_wstrb", {28'd0, iomem_wstrb}, 32'h1);
    chk("wr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    iomem_ready = 1'b1;
    tick();
    iomem_ready = 1'b0;
    chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_iomem_valid_drop", {31'd0, iomem_valid}, 32'd0);
    chk("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    chk("wr_gpio", gpio_reg, 32'h0000_00A5);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("wr_done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("wr_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Read back; cmd_wdata/cmd_wstrb must be ignored for reads
    set_cmd(1'b0, 32'h0300_0000, 32'hFFFF_FFFF, 4'b1111);
    tick();
    cmd_valid = 1'b0;
    chk("rd_iomem_wstrb", {28'd0, iomem_wstrb}, 32'h0);
    chk("rd_iomem_wdata", iomem_wdata, 32'h0);
    iomem_ready = 1'b1;
    tick();
    iomem_ready = 1'b0;
    chk("rd_rsp_rdata", rsp_rdata, 32'h0000_00A5);
    chk("rd_rsp_err", {31'd0, rsp_err}, 32'd0);

    // Backpressure: response held 5 cycles; a pending command and stray
    // iomem_ready pulses must not disturb it
    set_cmd(1'b0, 32'h0300_0004, 32'd0, 4'b0000);
    iomem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h0000_00A5);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    iomem_ready = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_taken_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("bp_taken_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Held command now accepted; responder never ready -> timeout after 8 cycles
    tick();
    cmd_valid = 1'b0;
    chk("to_iomem_addr", iomem_addr, 32'h0300_0004);
    vcount = 0;
    while (iomem_valid && vcount < 20) begin
      vcount++;
      tick();
    end
    chk("to_valid_cycles", vcount, 32'd8);
    chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Ready arriving on the 8th (expiry) cycle wins
    set_cmd(1'b0, 32'h0300_0000, 32'd0, 4'b0000);
    tick();
    cmd_valid = 1'b0;
    tick(7);
    chk("edge_valid_cycle8", {31'd0, iomem_valid}, 32'd1);
    iomem_ready = 1'b1;
    tick();
    iomem_ready = 1'b0;
    chk("edge_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("edge_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("edge_rsp_rdata", rsp_rdata, 32'h0000_00A5);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Write with zero strobes: no bus transfer, error response
    set_cmd(1'b1, 32'h0300_0000, 32'h1234_5678, 4'b0000);
    tick();
    cmd_valid = 1'b0;
    chk("ill_iomem_valid", {31'd0, iomem_valid}, 32'd0);
    chk("ill_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ill_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("ill_rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("ill_gpio", gpio_reg, 32'h0000_00A5);
    chk("ill_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Minimum 3-cycle command period: write byte 1
    set_cmd(1'b1, 32'h0300_0000, 32'h0000_3C00, 4'b0010);
    tick();
    cmd_valid = 1'b0;
    iomem_ready = 1'b1;
    chk("fast_iomem_wstrb", {28'd0, iomem_wstrb}, 32'h2);
    tick();
    iomem_ready = 1'b0;
    rsp_ready = 1'b1;
    chk("fast_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    tick();
    rsp_ready = 1'b0;
    chk("fast_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("fast_gpio", gpio_reg, 32'h0000_3CA5);

    // Read of the updated value
    set_cmd(1'b0, 32'h0300_0000, 32'd0, 4'b0000);
    tick();
    cmd_valid = 1'b0;
    iomem_ready = 1'b1;
    tick();
    iomem_ready = 1'b0;
    chk("rd2_rsp_rdata", rsp_rdata, 32'h0000_3CA5);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset mid-REQ aborts with no response
    set_cmd(1'b1, 32'h0300_0008, 32'h0000_0011, 4'b1111);
    tick();
    cmd_valid = 1'b0;
    chk("mid_iomem_valid", {31'd0, iomem_valid}, 32'd1);
    resetn = 1'b0;
    tick();
    chk("mid_rst_iomem_valid", {31'd0, iomem_valid}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("mid_rst_iomem_addr", iomem_addr, 32'd0);
    chk("mid_rst_iomem_wdata", iomem_wdata, 32'd0);
    resetn = 1'b1;
    tick();
    chk("mid_rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mid_rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // iomem_ready in IDLE is ignored
    iomem_ready = 1'b1;
    tick();
    iomem_ready = 1'b0;
    chk("idle_ready_busy", {31'd0, busy}, 32'd0);
    chk("idle_ready_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iomem_master.md
IOMEM_MASTER -- requirements
Module: iomem_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, SHALL set the maximum bus-wait cycles per transaction; 0 disables the timeout.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  SHALL be a synchronous, active-low reset.
REQ-004 cmd_valid  input  1  SHALL mark that a command is offered.
REQ-005 cmd_ready  output  1  SHALL mark that the block accepts a command this cycle.
REQ-006 cmd_write  input  1  SHALL select write (1) or read (0).
REQ-007 cmd_addr  input  32  SHALL carry the target address.
REQ-008 cmd_wdata  input  32  SHALL carry the write data.
REQ-009 cmd_wstrb  input  4  SHALL carry per-byte write enables.
REQ-010 rsp_valid  output  1  SHALL mark that a response is presented.
REQ-011 rsp_ready  input  1  SHALL mark that the consumer takes the response.
REQ-012 rsp_rdata  output  32  SHALL carry read data.
REQ-013 rsp_err  output  1  SHALL flag a timeout or illegal command.
REQ-014 iomem_valid  output  1  SHALL request a bus transfer.
REQ-015 iomem_ready  input  1  SHALL be the responder's completion pulse.
REQ-016 iomem_addr, iomem_wdata  output  32 each  SHALL drive bus address and write data.
REQ-017 iomem_wstrb  output  4  SHALL drive byte strobes; 4'b0000 means read.
REQ-018 iomem_rdata  input  32  SHALL carry responder read data.
REQ-019 busy  output  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, RESP.
REQ-021 In IDLE, cmd_ready SHALL be 1; cmd_valid&&cmd_ready at edge N SHALL register addr/wdata and go to REQ with iomem_valid=1 from cycle N+1.
REQ-022 For reads, iomem_wstrb SHALL be 4'b0000 and iomem_wdata 0, regardless of cmd_wstrb/cmd_wdata.
REQ-023 A write with cmd_wstrb==0 SHALL issue no bus transfer; the block SHALL go directly to RESP with rsp_err=1, rsp_rdata=0.
REQ-024 In REQ, iomem_addr/wdata/wstrb SHALL stay stable while iomem_valid=1.
REQ-025 iomem_ready sampled high at edge M in REQ SHALL drop iomem_valid at M+1 and present rsp_valid=1 at M+1; rsp_rdata=iomem_rdata for reads, 0 for writes; rsp_err=0.
REQ-026 A 16-bit wait counter SHALL count REQ cycles without iomem_ready; at the end of cycle TIMEOUT_CYCLES without ready, iomem_valid SHALL drop and RESP SHALL be entered with rsp_err=1, rsp_rdata=0.
REQ-027 If iomem_ready arrives on the expiry cycle, ready SHALL win (normal completion, rsp_err=0).
REQ-028 In RESP, rsp_valid and response fields SHALL hold until rsp_ready; rsp_valid&&rsp_ready at edge K SHALL return to IDLE, cmd_ready=1 at K+1.
REQ-029 cmd_ready SHALL be 0 outside IDLE; cmd_valid in REQ/RESP SHALL be ignored and not lost (it remains the consumer's responsibility).
REQ-030 iomem_ready while IDLE or RESP SHALL be ignored.
REQ-031 Minimum command-to-command period SHALL be 3 cycles (accept, 1-cycle ready, response taken immediately).

Reset
REQ-032 While resetn=0 at an edge, state SHALL go to IDLE and iomem_valid, iomem_addr, iomem_wdata, iomem_wstrb, rsp_valid, rsp_rdata, rsp_err, busy, wait counter SHALL become 0.
REQ-033 cmd_ready SHALL be 0 while resetn=0 and 1 from the first cycle after release.
REQ-034 Reset during REQ or RESP SHALL abort the transaction with no response produced.

Verification
REQ-035 Write: cmd addr=0x03000000, wdata=0x000000A5, wstrb=4'b0001; responder ready after 1 cycle -> iomem_wstrb=0001 during valid, rsp_valid with rsp_err=0, rsp_rdata=0; GPIO byte0=0xA5.
REQ-036 Read: cmd_write=0, addr=0x03000000; responder returns 0x000000A5 -> iomem_wstrb=0000, rsp_rdata=0x000000A5, rsp_err=0.
REQ-037 Timeout: TIMEOUT_CYCLES=8, responder never ready -> iomem_valid high exactly 8 cycles, then rsp_err=1, rsp_rdata=0.
REQ-038 Boundary: ready on cycle 8 with TIMEOUT_CYCLES=8 -> rsp_err=0; write with wstrb=0 -> no iomem_valid, rsp_err=1.
REQ-039 Backpressure/reset: rsp_ready held 0 for 5 cycles -> response stable, cmd_ready=0; resetn=0 mid-REQ -> iomem_valid=0 next edge, no rsp_valid, cmd_ready=1 after release.
